// File: rtl/ifu_fetch.sv
// ifu_fetch -- instruction-fetch stage.
//
// Owns the architectural PC and keeps at most one fetch outstanding on a
// valid/ready instruction-memory interface. Delivers {instr, pc, pc+4} as
// registered outputs to the decode stage. Load-hazard stalls freeze the
// outputs, and a one-entry hold buffer catches a response that lands during a
// stall. Branch/jump redirects squash the current instruction and refetch.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   ld_hz_nop          stall: hold the ifu_* outputs this cycle
//   redirect_en/_pc    taken branch/jump and its target (bits [1:0] ignored)
//   imem_req_*         fetch request (valid/ready, address = PC)
//   imem_resp_*        one-cycle fetch response
//   ifu_valid/_instr   instruction to decode (NOP_INSTR when not valid)
//   ifu_pc/_snxt_pc    PC of ifu_instr and that PC + 4

module ifu_fetch #(
  parameter logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_hz_nop,
  input  logic        redirect_en,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [63:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_instr,
  output logic        ifu_valid,
  output logic [31:0] ifu_instr,
  output logic [63:0] ifu_pc,
  output logic [63:0] ifu_snxt_pc
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [63:0] hold_pc_q, hold_pc_d;
  logic        ifu_valid_q, ifu_valid_d;
  logic [31:0] ifu_instr_q, ifu_instr_d;
  logic [63:0] ifu_pc_q, ifu_pc_d;
  logic [63:0] ifu_snxt_pc_q, ifu_snxt_pc_d;

  logic        req_fire;
  logic        resp_in_wait;
  logic        unused_redirect_lsbs;

  // Targets are word aligned; the low bits are deliberately discarded.
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign imem_req_valid = (state_q == ST_REQ) && !hold_valid_q && !rst;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign resp_in_wait   = (state_q == ST_WAIT) && imem_resp_valid;

  assign ifu_valid   = ifu_valid_q;
  assign ifu_instr   = ifu_instr_q;
  assign ifu_pc      = ifu_pc_q;
  assign ifu_snxt_pc = ifu_snxt_pc_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    hold_valid_d  = hold_valid_q;
    hold_instr_d  = hold_instr_q;
    hold_pc_d     = hold_pc_q;
    ifu_valid_d   = ifu_valid_q;
    ifu_instr_d   = ifu_instr_q;
    ifu_pc_d      = ifu_pc_q;
    ifu_snxt_pc_d = ifu_snxt_pc_q;

    if (redirect_en) begin
      pc_d         = {redirect_pc[63:2], 2'b00};
      hold_valid_d = 1'b0;
      ifu_valid_d  = 1'b0;
      ifu_instr_d  = NOP_INSTR;
      // A fetch left outstanding by the squash must be swallowed in DROP.
      // In DROP the awaited response, if it arrives now, is the one being
      // discarded, so only then is it safe to return to REQ.
      unique case (state_q)
        ST_REQ:  state_d = req_fire ? ST_DROP : ST_REQ;
        ST_WAIT: state_d = imem_resp_valid ? ST_REQ : ST_DROP;
        ST_DROP: state_d = imem_resp_valid ? ST_REQ : ST_DROP;
        default: state_d = ST_REQ;
      endcase
    end else begin
      // Output register: buffered instr first, then a fresh response, else bubble.
      if (!ld_hz_nop) begin
        if (hold_valid_q) begin
          ifu_valid_d   = 1'b1;
          ifu_instr_d   = hold_instr_q;
          ifu_pc_d      = hold_pc_q;
          ifu_snxt_pc_d = hold_pc_q + 64'd4;
          hold_valid_d  = 1'b0;
        end else if (resp_in_wait) begin
          ifu_valid_d   = 1'b1;
          ifu_instr_d   = imem_resp_instr;
          ifu_pc_d      = pc_q;
          ifu_snxt_pc_d = pc_q + 64'd4;
        end else begin
          ifu_valid_d   = 1'b0;
          ifu_instr_d   = NOP_INSTR;
        end
      end

      // A response that cannot go straight to the outputs parks in the buffer.
      if (resp_in_wait && (ld_hz_nop || hold_valid_q)) begin
        hold_valid_d = 1'b1;
        hold_instr_d = imem_resp_instr;
        hold_pc_d    = pc_q;
      end

      unique case (state_q)
        ST_REQ: begin
          if (req_fire) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_resp_valid) begin
            state_d = ST_REQ;
            pc_d    = pc_q + 64'd4;
          end
        end
        ST_DROP: begin
          if (imem_resp_valid) state_d = ST_REQ;
        end
        default: state_d = ST_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_REQ;
      pc_q          <= RESET_PC;
      hold_valid_q  <= 1'b0;
      hold_instr_q  <= NOP_INSTR;
      hold_pc_q     <= '0;
      ifu_valid_q   <= 1'b0;
      ifu_instr_q   <= NOP_INSTR;
      ifu_pc_q      <= '0;
      ifu_snxt_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      hold_valid_q  <= hold_valid_d;
      hold_instr_q  <= hold_instr_d;
      hold_pc_q     <= hold_pc_d;
      ifu_valid_q   <= ifu_valid_d;
      ifu_instr_q   <= ifu_instr_d;
      ifu_pc_q      <= ifu_pc_d;
      ifu_snxt_pc_q <= ifu_snxt_pc_d;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

  logic        clk;
  logic        rst;
  logic        ld_hz_nop;
  logic        redirect_en;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_instr;
  logic        ifu_valid;
  logic [31:0] ifu_instr;
  logic [63:0] ifu_pc;
  logic [63:0] ifu_snxt_pc;

  int unsigned checks = 0;
  int unsigned errors = 0;

  ifu_fetch #(
    .RESET_PC  (64'h0000_0000_8000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ld_hz_nop       (ld_hz_nop),
    .redirect_en     (redirect_en),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_instr (imem_resp_instr),
    .ifu_valid       (ifu_valid),
    .ifu_instr       (ifu_instr),
    .ifu_pc          (ifu_pc),
    .ifu_snxt_pc     (ifu_snxt_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] ins,
                           input logic [63:0] pc, input logic [63:0] snxt);
    check({tag, ".valid"}, {63'd0, ifu_valid}, {63'd0, v});
    check({tag, ".instr"}, {32'd0, ifu_instr}, {32'd0, ins});
    check({tag, ".pc"},    ifu_pc,   pc);
    check({tag, ".snxt"},  ifu_snxt_pc, snxt);
  endtask

  task automatic check_req(input string tag, input logic v, input logic [63:0] addr);
    check({tag, ".req_valid"}, {63'd0, imem_req_valid}, {63'd0, v});
    if (v) check({tag, ".req_addr"}, imem_req_addr, addr);
  endtask

  initial begin
    rst = 1'b1; ld_hz_nop = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_instr = '0;

    // Reset state
    tick(); tick();
    check_out("reset", 1'b0, 32'h13, 64'h0, 64'h0);
    check_req("reset_req", 1'b0, 64'h0);
    rst = 1'b0; #1;
    check_req("post_reset_req", 1'b1, 64'h8000_0000);

    // 1: zero-wait fetch
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_instr = 32'h0010_0093;
    check_req("t1_wait", 1'b0, 64'h0);
    tick();
    imem_resp_valid = 1'b0;
    check_out("t1_out", 1'b1, 32'h0010_0093, 64'h8000_0000, 64'h8000_0004);
    check_req("t1_next_req", 1'b1, 64'h8000_0004);

    // 2: stall for three cycles while a response lands in the hold buffer
    ld_hz_nop = 1'b1; imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_instr = 32'h0020_0113;
    check_out("t2_stall1", 1'b1, 32'h0010_0093, 64'h8000_0000, 64'h8000_0004);
    tick();
    imem_resp_valid = 1'b0;
    check_out("t2_stall2", 1'b1, 32'h0010_0093, 64'h8000_0000, 64'h8000_0004);
    check_req("t2_held_noreq", 1'b0, 64'h0);
    tick();
    check_out("t2_stall3", 1'b1, 32'h0010_0093, 64'h8000_0000, 64'h8000_0004);
    check_req("t2_held_noreq3", 1'b0, 64'h0);
    ld_hz_nop = 1'b0;
    tick();
    check_out("t2_release", 1'b1, 32'h0020_0113, 64'h8000_0004, 64'h8000_0008);
    check_req("t2_req_after", 1'b1, 64'h8000_0008);

    // 3: redirect while waiting; the outstanding response is dropped
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    check_out("t3_bubble", 1'b0, 32'h13, 64'h8000_0004, 64'h8000_0008);
    redirect_en = 1'b1; redirect_pc = 64'h8000_0103;
    tick();
    redirect_en = 1'b0;
    check("t3_redir_valid", {63'd0, ifu_valid}, 64'd0);
    check("t3_redir_instr", {32'd0, ifu_instr}, 64'h13);
    check_req("t3_drop_noreq", 1'b0, 64'h0);
    imem_resp_valid = 1'b1; imem_resp_instr = 32'hDEAD_BEEF;
    tick();
    imem_resp_valid = 1'b0;
    check("t3_dropped_valid", {63'd0, ifu_valid}, 64'd0);
    check("t3_dropped_instr", {32'd0, ifu_instr}, 64'h13);
    check_req("t3_new_req", 1'b1, 64'h8000_0100);

    // 4: redirect, stall and response in the same cycle
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect_en = 1'b1; redirect_pc = 64'h8000_0200; ld_hz_nop = 1'b1;
    imem_resp_valid = 1'b1; imem_resp_instr = 32'hCAFE_BABE;
    tick();
    redirect_en = 1'b0; ld_hz_nop = 1'b0; imem_resp_valid = 1'b0;
    check("t4_valid", {63'd0, ifu_valid}, 64'd0);
    check("t4_instr", {32'd0, ifu_instr}, 64'h13);
    check_req("t4_req", 1'b1, 64'h8000_0200);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_instr = 32'h0030_0193;
    tick();
    imem_resp_valid = 1'b0;
    check_out("t4_refetch", 1'b1, 32'h0030_0193, 64'h8000_0200, 64'h8000_0204);

    // 5: redirect to the top of the address space; pc+4 wraps
    redirect_en = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    redirect_en = 1'b0;
    check_req("t5_req_top", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_instr = 32'h0040_0213;
    tick();
    imem_resp_valid = 1'b0;
    check_out("t5_wrap", 1'b1, 32'h0040_0213, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0);
    check_req("t5_req_zero", 1'b1, 64'h0);

    // Redirect in the same cycle a request is accepted -> DROP
    imem_req_ready = 1'b1; redirect_en = 1'b1; redirect_pc = 64'h8000_0300;
    tick();
    imem_req_ready = 1'b0; redirect_en = 1'b0;
    check_req("t5b_drop_noreq", 1'b0, 64'h0);
    imem_resp_valid = 1'b1; imem_resp_instr = 32'h1234_5678;
    tick();
    imem_resp_valid = 1'b0;
    check("t5b_dropped_valid", {63'd0, ifu_valid}, 64'd0);
    check_req("t5b_req", 1'b1, 64'h8000_0300);

    // 6: reset while waiting, response arrives afterwards
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; rst = 1'b1;
    tick();
    check_req("t6_rst_noreq", 1'b0, 64'h0);
    rst = 1'b0; imem_resp_valid = 1'b1; imem_resp_instr = 32'h1111_1111;
    check_out("t6_reset", 1'b0, 32'h13, 64'h0, 64'h0);
    tick();
    imem_resp_valid = 1'b0;
    check_out("t6_late_resp", 1'b0, 32'h13, 64'h0, 64'h0);
    check_req("t6_req", 1'b1, 64'h8000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
